// File: rtl/radix4_booth_mul.sv
// Sequential radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU: 17 iterations, one op in flight.
// Opcode encoding: 0=MUL_NONE 1=MUL 2=MULH 3=MULHSU 4=MULHU. Optional zero early-out: RADIX4_MUL_EARLY_OUT_EN.
module radix4_booth_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_in_valid_i,
  output logic             mul_in_ready_o,
  input  logic [WIDTH-1:0] mul_in_data_a_i,
  input  logic [WIDTH-1:0] mul_in_data_b_i,
  input  logic [2:0]       mul_in_opcode_i,
  output logic             mul_out_valid_o,
  input  logic             mul_out_ready_i,
  output logic [WIDTH-1:0] mul_out_data_o
);

  localparam int unsigned XW    = WIDTH + 2;
  localparam int unsigned AW    = XW + 1;
  localparam int unsigned PW    = AW + XW;
  localparam int unsigned ITERS = XW / 2;
  localparam int unsigned CW    = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
  typedef enum logic [2:0] {
    MUL_NONE = 3'd0,
    MUL      = 3'd1,
    MULH     = 3'd2,
    MULHSU   = 3'd3,
    MULHU    = 3'd4
  } mul_op_e;

  state_e           state_q, state_d;
  mul_op_e          op_q, op_in;
  logic [XW-1:0]    m_q;
  logic [PW-1:0]    p_q, p_d;
  logic             booth_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q, result_d;

  logic             in_fire, out_fire, op_valid, zero_op, skip_calc;
  logic             a_sgn, b_sgn;
  logic [XW-1:0]    a_ext, b_ext;
  logic [AW-1:0]    m_ext, m_dbl, addend, acc_sum;

  assign in_fire  = mul_in_valid_i & mul_in_ready_o;
  assign out_fire = mul_out_valid_o & mul_out_ready_i;
  assign op_in    = mul_op_e'(mul_in_opcode_i);
  assign op_valid = op_in inside {MUL, MULH, MULHSU, MULHU};

`ifdef RADIX4_MUL_EARLY_OUT_EN
  assign zero_op = (mul_in_data_a_i == '0) || (mul_in_data_b_i == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Unknown opcodes are treated as MUL_NONE: straight to S_DONE with a zero result.
  assign skip_calc = !op_valid || zero_op;

  assign a_sgn = (op_in != MULHU);
  assign b_sgn = (op_in == MUL) || (op_in == MULH);
  assign a_ext = {{2{a_sgn & mul_in_data_a_i[WIDTH-1]}}, mul_in_data_a_i};
  assign b_ext = {{2{b_sgn & mul_in_data_b_i[WIDTH-1]}}, mul_in_data_b_i};

  assign m_ext = {m_q[XW-1], m_q};
  assign m_dbl = {m_q, 1'b0};

  always_comb begin
    addend = '0;
    case ({p_q[1:0], booth_q})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_dbl;
      3'b100:         addend = '0 - m_dbl;
      3'b101, 3'b110: addend = '0 - m_ext;
      default:        addend = '0;
    endcase
  end

  // Add into the accumulator, then arithmetic shift of the whole 69-bit register by two.
  assign acc_sum  = p_q[PW-1:XW] + addend;
  assign p_d      = {{2{acc_sum[AW-1]}}, acc_sum, p_q[XW-1:2]};
  assign result_d = (op_q == MUL) ? p_d[WIDTH-1:0] : p_d[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_fire) state_d = skip_calc ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE: if (out_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mul_in_ready_o  = (state_q == S_IDLE);
    mul_out_valid_o = (state_q == S_DONE);
    mul_out_data_o  = result_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= MUL_NONE;
      m_q      <= '0;
      p_q      <= '0;
      booth_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            op_q     <= op_valid ? op_in : MUL_NONE;
            m_q      <= a_ext;
            p_q      <= {{AW{1'b0}}, b_ext};
            booth_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
          end
        end
        S_CALC: begin
          p_q     <= p_d;
          booth_q <= p_q[1];
          if (cnt_q == LAST) begin
            cnt_q    <= '0;
            result_q <= result_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
